// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame.
module uart_tx_serializer #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_Start,
    input  logic [7:0] UART_Tx_Data,
    input  logic       Parity,
    output logic       tx,
    output logic       tx_send,
    output logic       UART_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_TWO_STOP_EN
    localparam bit TWO_STOP = 1'b1;
`else
    localparam bit TWO_STOP = 1'b0;
`endif

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic             stop2, stop2_n;
    logic [7:0]       shadow, shadow_n;
    logic             par_en, par_en_n;
    logic             start_q;
    logic             tx_n, send_n, bit_end, done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            stop2   <= 1'b0;
            shadow  <= '0;
            par_en  <= 1'b0;
            start_q <= 1'b1;  // a level held through reset must not launch
            tx      <= 1'b1;
            tx_send <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            stop2   <= stop2_n;
            shadow  <= shadow_n;
            par_en  <= par_en_n;
            start_q <= Tx_Start;
            tx      <= tx_n;
            tx_send <= send_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        stop2_n  = stop2;
        shadow_n = shadow;
        par_en_n = par_en;
        bit_end  = (cnt == CNT_LAST);
        done_c   = 1'b0;
        tx_n     = 1'b1;
        send_n   = 1'b0;

        if (state != IDLE)
            cnt_n = bit_end ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                if (Tx_Start && !start_q) begin
                    state_n  = START;
                    shadow_n = UART_Tx_Data;
                    par_en_n = Parity;
                    cnt_n    = '0;
                    bit_n    = '0;
                    stop2_n  = 1'b0;
                end
            end
            START:  if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_n = par_en ? PARITY : STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                if (bit_end) begin
                    if (TWO_STOP && !stop2) begin
                        stop2_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        done_c  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so the line changes on the launch edge.
        case (state_n)
            START:   begin tx_n = 1'b0;            send_n = 1'b1; end
            DATA:    begin tx_n = shadow_n[bit_n]; send_n = 1'b1; end
            PARITY:  begin tx_n = ^shadow_n;       send_n = 1'b1; end
            STOP:    begin tx_n = 1'b1;            send_n = 1'b1; end
            default: begin tx_n = 1'b1;            send_n = 1'b0; end
        endcase
    end

    assign UART_Tx_Done = done_c;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus pushes expected frames, a monitor checks the line.
module tb_uart_tx_serializer;

    localparam int CPB = 10;
`ifdef UART_TX_TWO_STOP_EN
    localparam int XS = 1;
`else
    localparam int XS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Tx_Start = 1'b1;
    logic [7:0] UART_Tx_Data = 8'h00;
    logic       Parity = 1'b0;
    logic       tx, tx_send, UART_Tx_Done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] bits;   // time order: bits[n-1] is sent first
        int          n;
    } frame_t;

    frame_t exp_q[$];

    uart_tx_serializer #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk(clk), .reset(reset), .Tx_Start(Tx_Start), .UART_Tx_Data(UART_Tx_Data),
        .Parity(Parity), .tx(tx), .tx_send(tx_send), .UART_Tx_Done(UART_Tx_Done)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Extra stop bits (two-stop build) are appended as trailing ones.
    task automatic push_frame(input logic [11:0] seq, input int n);
        frame_t f;
        logic [11:0] xmask;
        xmask  = 12'((1 << XS) - 1);
        f.bits = (seq << XS) | xmask;
        f.n    = n + XS;
        exp_q.push_back(f);
    endtask

    task automatic launch(input logic [7:0] d, input logic p, input logic [11:0] seq, input int n);
        @(posedge clk); #1 Tx_Start = 1'b0;
        @(posedge clk); #1;
        UART_Tx_Data = d;
        Parity       = p;
        Tx_Start     = 1'b1;
        push_frame(seq, n);
        @(negedge clk);
        chk1("pre_launch_send", tx_send, 1'b0);
        @(negedge clk);
        chk1("launch_tx", tx, 1'b0);
        chk1("launch_send", tx_send, 1'b1);
        Tx_Start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (tx_send && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk1("idle_timeout", tx_send, 1'b0);
    endtask

    // Monitor: walks each frame cycle by cycle against the queued expectation.
    initial begin
        frame_t cur;
        int     cyc = 0;
        bit     active = 0;
        bit     rogue = 0;
        cur.bits = '0;
        cur.n    = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
                rogue  = 0;
            end else begin
                if (!active && tx_send && !rogue) begin
                    if (exp_q.size() == 0) begin
                        chk1("unexpected_frame", tx_send, 1'b0);
                        rogue = 1;
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1;
                        cyc    = 0;
                    end
                end
                if (!tx_send) rogue = 0;
                if (active) begin
                    chk1("mon_tx", tx, cur.bits[cur.n - 1 - cyc / CPB]);
                    chk1("mon_send", tx_send, 1'b1);
                    chk1("mon_done", UART_Tx_Done, cyc == cur.n * CPB - 1);
                    cyc++;
                    if (cyc == cur.n * CPB) active = 0;
                end else if (!tx_send) begin
                    chk1("idle_tx", tx, 1'b1);
                    chk1("idle_done", UART_Tx_Done, 1'b0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset with Tx_Start held high: no frame may launch.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_send", tx_send, 1'b0);
        chk1("rst_done", UART_Tx_Done, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (200) begin
            @(negedge clk);
            chk1("held_start_tx", tx, 1'b1);
            chk1("held_start_send", tx_send, 1'b0);
        end

        launch(8'hA5, 1'b0, 12'b0101001011, 10);
        wait_idle();
        launch(8'h07, 1'b1, 12'b01110000011, 11);
        wait_idle();
        launch(8'hA5, 1'b1, 12'b01010010101, 11);
        wait_idle();

        // Busy ignore: a new edge and data change mid-frame must not matter.
        launch(8'h3C, 1'b0, 12'b0001111001, 10);
        repeat (37) @(posedge clk);
        #1;
        Tx_Start     = 1'b0;
        UART_Tx_Data = 8'hFF;
        Parity       = 1'b1;
        @(posedge clk); #1 Tx_Start = 1'b1;
        wait_idle();
        repeat (30) @(negedge clk);
        Tx_Start = 1'b0;

        // Reset during cycle 35 of a 0x00 frame.
        launch(8'h00, 1'b0, 12'b0000000001, 10);
        repeat (34) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk1("midrst_tx", tx, 1'b1);
        chk1("midrst_send", tx_send, 1'b0);
        chk1("midrst_done", UART_Tx_Done, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        launch(8'h81, 1'b1, 12'b01000000101, 11);
        wait_idle();

        // Back-to-back: relaunch in the first idle cycle after Done.
        launch(8'h55, 1'b0, 12'b0101010101, 10);
        c = 1;
        while (!UART_Tx_Done && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk_int("done_cycle", c, (10 + XS) * CPB);
        @(posedge clk); #1;
        UART_Tx_Data = 8'hA5;
        Parity       = 1'b0;
        Tx_Start     = 1'b1;
        push_frame(12'b0101001011, 10);
        @(negedge clk);
        chk1("gap_send", tx_send, 1'b0);
        chk1("gap_tx", tx, 1'b1);
        @(negedge clk);
        chk1("b2b_start_tx", tx, 1'b0);
        chk1("b2b_start_send", tx_send, 1'b1);
        Tx_Start = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk_int("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit engine. Serializes the byte, parity-enable and start strobe produced by the Tx register encoder onto the serial line.
- Reports busy status (tx_send) and a frame-complete pulse (UART_Tx_Done) back to the register decode block, which uses them to build the Tx status register.
- Sits between the UART register decode block and the board TX pin, mirroring the existing UART receiver.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE: clocks per serial bit. Must be >= 2; elaboration error otherwise.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Tx_Start  in  1  level request from the Tx register; the rising edge launches a frame.
- UART_Tx_Data  in  8  byte to send; latched at launch.
- Parity  in  1  1 = append even-parity bit; latched at launch.
- tx  out  1  serial line, idle high.
- tx_send  out  1  high while a frame is on the line.
- UART_Tx_Done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: tx=1, tx_send=0, UART_Tx_Done=0, state=IDLE, bit counter=0, baud counter=0, Tx_Start edge register=1.
- Edge register reset to 1: Tx_Start held high through reset does not launch a frame. A 0->1 transition must be seen after reset.
- Launch: in IDLE, a sampled Tx_Start rising edge (current 1, previous 0) does the following:
  - latches UART_Tx_Data and Parity into shadow registers;
  - enters START.
  - On the next clock edge tx=0 and tx_send=1, a latency of one cycle from the sampled edge.
- Rising edges outside IDLE are ignored, not queued. Input changes mid-frame have no effect on the frame in progress.
- Baud counter runs 0..CLKS_PER_BIT-1. Each state holds tx for exactly CLKS_PER_BIT cycles. Counter width is $clog2(CLKS_PER_BIT).
- States:
  - IDLE: tx=1, tx_send=0.
  - START: tx=0, one bit time, then DATA.
  - DATA: tx=shadow[bit_idx], LSB first. bit_idx runs 0..7, advancing at each bit-time end. After bit 7, go to PARITY if the latched Parity=1, else STOP.
  - PARITY: tx = XOR of the 8 shadow bits (even parity: total ones including the parity bit is even). One bit time, then STOP.
  - STOP: tx=1, one bit time. On the final cycle: UART_Tx_Done=1 for that single cycle, then IDLE with tx_send=0 from the next cycle.
- Frame length: 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT with parity, measured from the first tx=0 cycle to the last stop cycle inclusive.
- Back-to-back: a Tx_Start rising edge sampled in the first IDLE cycle after STOP launches immediately, so the minimum idle gap is 1 cycle.
- Reset mid-frame: the next edge forces all reset values. tx returns high, no Done pulse, and the partial frame is abandoned.
- tx and tx_send are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles. Frame length becomes 11 (no parity) or 12 (parity) bit times. UART_Tx_Done pulses on the last cycle of the second stop bit.
- Undefined: single stop bit as described above.

Test Plan (CLK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10):
- Idle/reset: Tx_Start held 1 across reset release -> tx stays 1 and tx_send stays 0 for 200 cycles. Then drop to 0 and raise -> frame starts one cycle after the rise.
- Data 0xA5, Parity=0 -> tx sequence 0,1,0,1,0,0,1,0,1,1 at 10 cycles per bit (100 cycles). tx_send high for all 100 cycles. UART_Tx_Done single pulse on cycle 100.
- Data 0x07, Parity=1 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1 over 110 cycles. Data 0xA5, Parity=1 -> parity bit 0.
- Busy ignore: launch 0x3C, then change data to 0xFF and toggle Tx_Start 0->1 at cycle 40 -> line shows 0x3C only. No second frame follows. Exactly one Done pulse.
- Reset mid-frame: assert reset at cycle 35 of a 0x00 frame -> tx=1 and tx_send=0 on the next edge. No Done pulse. A new launch afterwards sends a correct full frame.
- With UART_TX_TWO_STOP_EN: 0x55, Parity=0 -> stop high for 20 cycles. Done pulses on cycle 110. A back-to-back launch starts its start bit on cycle 112.
